// File: rtl/sc_fp_multiplier.sv
// Stochastic-computing IEEE-754 single-precision multiplier: LFSR bit streams, AND, popcount, normalise.
// Optional build macro SC_MUL_SPECIALS_EN adds zero/inf/NaN classification with a one-edge bypass.
module sc_fp_multiplier #(
  parameter int MANT_BITS = 8,
  parameter int SEED_A    = 1,
  parameter int SEED_B    = 90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p,
  output logic        busy
);
  localparam int N  = MANT_BITS;
  localparam int F  = N - 1;
  localparam int SA_MOD = SEED_A % (1 << N);
  localparam int SB_MOD = SEED_B % (1 << N);
  localparam logic [N-1:0] SEED_A_N = (SA_MOD == 0) ? N'(1) : N'(SA_MOD);
  localparam logic [N-1:0] SEED_B_N = (SB_MOD == 0) ? N'(1) : N'(SB_MOD);
  localparam logic [N-1:0] LAST_CNT = N'((1 << N) - 2);

  function automatic logic [11:0] tap_mask(input int n);
    case (n)
      4:       return 12'h00C;
      5:       return 12'h014;
      6:       return 12'h030;
      7:       return 12'h060;
      9:       return 12'h110;
      10:      return 12'h240;
      11:      return 12'h500;
      12:      return 12'h829;
      default: return 12'h0B8;
    endcase
  endfunction

  localparam logic [N-1:0] TAPS = N'(tap_mask(N));

  function automatic logic [N-1:0] lfsr_step(input logic [N-1:0] v);
    return {v[N-2:0], ^(v & TAPS)};
  endfunction

  function automatic logic [N-1:0] bit_rev(input logic [N-1:0] v);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[N-1-i];
    return r;
  endfunction

  function automatic logic [3:0] lead_zeros(input logic [N-1:0] v);
    logic [3:0] n;
    logic       found;
    n     = 4'(N);
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 4'(N - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Flush-to-zero and overflow-to-infinity clamp on the packed result.
  function automatic logic [31:0] pack_sat(input logic sgn, input logic signed [9:0] e,
                                           input logic [F-1:0] frac, input logic is_zero);
    if (is_zero || e <= 10'sd0) return {sgn, 31'b0};
    if (e >= 10'sd255)          return {sgn, 8'hFF, 23'b0};
    return {sgn, e[7:0], frac, {(23 - F){1'b0}}};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic [N-1:0] lfsr_a, lfsr_b, acc, cnt;
  logic [N-1:0] ma_q, mb_q;
  logic [7:0]   ea_q, eb_q;
  logic         sgn_q;
  logic         sa, sb;
  logic [3:0]   lz;
  logic [N-1:0] acc_shift;
  logic signed [9:0] e_norm;
  logic         special_hit;
  logic [31:0]  special_p;
  logic         unused_bits;

  assign unused_bits = ^{a[22-F:0], b[22-F:0]};
  assign in_ready    = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  assign sa        = (ma_q > lfsr_a);
  assign sb        = (mb_q > bit_rev(lfsr_b));
  assign lz        = lead_zeros(acc);
  assign acc_shift = acc << (lz + 4'd1);
  assign e_norm    = $signed({2'b00, ea_q}) + $signed({2'b00, eb_q}) - 10'sd126
                     - $signed({6'b0, lz});

`ifdef SC_MUL_SPECIALS_EN
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sgn_in;
  always_comb begin
    a_zero      = (a[30:23] == 8'h00);
    b_zero      = (b[30:23] == 8'h00);
    a_inf       = (a[30:23] == 8'hFF) && (a[22:0] == 23'b0);
    b_inf       = (b[30:23] == 8'hFF) && (b[22:0] == 23'b0);
    a_nan       = (a[30:23] == 8'hFF) && (a[22:0] != 23'b0);
    b_nan       = (b[30:23] == 8'hFF) && (b[22:0] != 23'b0);
    sgn_in      = a[31] ^ b[31];
    special_hit = 1'b1;
    special_p   = 32'h0;
    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero))
      special_p = 32'h7FC00000;
    else if (a_inf || b_inf)
      special_p = {sgn_in, 8'hFF, 23'b0};
    else if (a_zero || b_zero)
      special_p = {sgn_in, 31'b0};
    else
      special_hit = 1'b0;
  end
`else
  assign special_hit = 1'b0;
  assign special_p   = 32'h0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = special_hit ? DONE : RUN;
      RUN:     if (cnt == LAST_CNT) state_d = NORM;
      NORM:    state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      p         <= 32'h0;
      acc       <= '0;
      cnt       <= '0;
      lfsr_a    <= SEED_A_N;
      lfsr_b    <= SEED_B_N;
    end else begin
      state_q <= state_d;
      case (state_q)
        // IDLE: accept reloads the streams so each operand pair is deterministic
        IDLE: if (in_valid) begin
          acc    <= '0;
          cnt    <= '0;
          lfsr_a <= SEED_A_N;
          lfsr_b <= SEED_B_N;
          if (special_hit) begin
            p         <= special_p;
            out_valid <= 1'b1;
          end
        end
        // RUN: one stream sample per cycle, 2^N-1 samples in total
        RUN: begin
          acc    <= acc + {{(N-1){1'b0}}, sa & sb};
          cnt    <= cnt + 1'b1;
          lfsr_a <= lfsr_step(lfsr_a);
          lfsr_b <= lfsr_step(lfsr_b);
        end
        // NORM: renormalise the popcount into an IEEE-754 word
        NORM: begin
          p         <= pack_sat(sgn_q, e_norm, acc_shift[N-1:1], acc == '0);
          out_valid <= 1'b1;
        end
        // DONE: hold the result until the consumer takes it
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && in_valid) begin
      sgn_q <= a[31] ^ b[31];
      ea_q  <= a[30:23];
      eb_q  <= b[30:23];
      ma_q  <= {1'b1, a[22 -: F]};
      mb_q  <= {1'b1, b[22 -: F]};
    end
  end
endmodule

// File: tb/tb_sc_fp_multiplier.sv
// Directed bench for sc_fp_multiplier (MANT_BITS=8) with a bit-accurate stream model.
module tb_sc_fp_multiplier;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        in_ready, out_valid, busy;
  logic [31:0] p;

  int n_tests = 0;
  int n_fail  = 0;

  sc_fp_multiplier #(.MANT_BITS(8), .SEED_A(1), .SEED_B(90)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: 8-bit Fibonacci LFSRs, polynomial x^8+x^6+x^5+x^4+1.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [7:0] la, lb, rb, ma, mb, sh;
    int cnt, lz, e;
    logic s;
    la = 8'd1; lb = 8'd90; cnt = 0;
    ma = {1'b1, x[22:16]};
    mb = {1'b1, y[22:16]};
    s  = x[31] ^ y[31];
    for (int i = 0; i < 255; i++) begin
      for (int k = 0; k < 8; k++) rb[k] = lb[7-k];
      if ((ma > la) && (mb > rb)) cnt++;
      la = {la[6:0], la[7] ^ la[5] ^ la[4] ^ la[3]};
      lb = {lb[6:0], lb[7] ^ lb[5] ^ lb[4] ^ lb[3]};
    end
    if (cnt == 0) return {s, 31'b0};
    lz = 0;
    while (((cnt << lz) & 128) == 0) lz++;
    e  = int'(x[30:23]) + int'(y[30:23]) - 126 - lz;
    sh = 8'(cnt << (lz + 1));
    if (e <= 0) return {s, 31'b0};
    if (e >= 255) return {s, 8'hFF, 23'b0};
    return {s, 8'(e), sh[7:1], 16'b0};
  endfunction

  function automatic real f2r(input logic [31:0] x);
    real m;
    m = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (real'(x[30:23]) - 127.0));
    return x[31] ? -m : m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] got,
                         input logic [31:0] x, input logic [31:0] y);
    real t, err;
    t   = f2r(x) * f2r(y);
    err = (f2r(got) - t) / t;
    if (err < 0.0) err = -err;
    n_tests++;
    assert (err <= 1.0 / 32.0) else begin
      n_fail++;
      $error("FAIL %s: got %h (rel err %f) expected within %f of %f", tag, got, err, 1.0 / 32.0, t);
    end
  endtask

  // Launch one operation; lat = clock edges from the accepting edge to out_valid.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h12345678;
    lat = 0;
    while (!out_valid && lat < 1000) begin
      @(posedge clk); #1;
      lat++;
    end
    res = p;
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready_back"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] res, exp_t2;
    int lat;

    // Reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_p", p, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // T1: 1.0 * 1.0, popcount 63 -> 0x3F7C0000
    run_op(32'h3F800000, 32'h3F800000, res, lat);
    chk("t1_latency", 32'(lat), 32'd256);
    chk("t1_p_hand", res, 32'h3F7C0000);
    chk("t1_p_model", res, model(32'h3F800000, 32'h3F800000));
    chk_tol("t1_tol", res, 32'h3F800000, 32'h3F800000);
    finish_op("t1");

    // T2 + T4: -1.5 * 2.0, result held under backpressure
    exp_t2 = model(32'hBFC00000, 32'h40000000);
    run_op(32'hBFC00000, 32'h40000000, res, lat);
    chk("t2_latency", 32'(lat), 32'd256);
    chk("t2_sign", 32'(res[31]), 32'd1);
    chk("t2_p_model", res, exp_t2);
    chk_tol("t2_tol", res, 32'hBFC00000, 32'h40000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; a = 32'h40400000; b = 32'h40400000;
      @(posedge clk); #1;
      chk("t4_p_hold", p, exp_t2);
      chk("t4_in_ready_low", 32'(in_ready), 32'd0);
      chk("t4_out_valid_hold", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    finish_op("t4");
    @(posedge clk); #1;
    chk("t4_no_stray_op", 32'(busy), 32'd0);

    // T3: overflow to inf, underflow flush to zero
    run_op(32'h7F000000, 32'h7F000000, res, lat);
    chk("t3_inf", res, 32'h7F800000);
    chk("t3_inf_model", res, model(32'h7F000000, 32'h7F000000));
    finish_op("t3a");
    run_op(32'h00800000, 32'h00800000, res, lat);
    chk("t3_flush", res, 32'h00000000);
    finish_op("t3b");

    // T5: asynchronous reset during RUN, then a clean rerun of T1
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_p_zero", p, 32'h0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op(32'h3F800000, 32'h3F800000, res, lat);
    chk("t5_rerun_latency", 32'(lat), 32'd256);
    chk("t5_rerun_p", res, 32'h3F7C0000);
    finish_op("t5");

`ifdef SC_MUL_SPECIALS_EN
    // T6: classified operands bypass the stream path
    run_op(32'h00000000, 32'h40400000, res, lat);
    chk("t6_zero_latency", 32'(lat), 32'd0);
    chk("t6_zero_p", res, 32'h00000000);
    finish_op("t6a");
    run_op(32'h7F800000, 32'h00000000, res, lat);
    chk("t6_inf_times_zero", res, 32'h7FC00000);
    finish_op("t6b");
    run_op(32'hFF800000, 32'h40400000, res, lat);
    chk("t6_neg_inf", res, 32'hFF800000);
    finish_op("t6c");
`else
    // T6: without classification, a zero exponent takes the full stream path
    run_op(32'h00000000, 32'h40400000, res, lat);
    chk("t6_latency", 32'(lat), 32'd256);
    chk("t6_nonzero", 32'(res != 32'h0), 32'd1);
    chk("t6_p_model", res, model(32'h00000000, 32'h40400000));
    finish_op("t6");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
